// File: rtl/fifo_wr_arbiter_if.sv
// Write-side bundle between NREQ requesters, the arbiter and a shared FIFO.
// master: arbiter side; slave: requester/FIFO side.
interface fifo_wr_arbiter_if #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned DW   = 8
);
  logic [NREQ-1:0]    req;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    gnt;
  logic [NREQ-1:0]    ack;
  logic               buf_full;
  logic               wr_en;
  logic [DW-1:0]      buf_in;
  logic               busy;

  modport master (
    input  req, req_data, buf_full,
    output gnt, ack, wr_en, buf_in, busy
  );

  modport slave (
    output req, req_data, buf_full,
    input  gnt, ack, wr_en, buf_in, busy
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter funnelling NREQ requesters into one FIFO write port.
// Define FIFO_WR_ARB_STATS_EN to add saturating words_cnt/stall_cnt outputs.
module fifo_wr_arbiter #(
  parameter int unsigned NREQ      = 4,
  parameter int unsigned DW        = 8,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  fifo_wr_arbiter_if.master bus
`ifdef FIFO_WR_ARB_STATS_EN
  ,
  output logic [15:0]       words_cnt,
  output logic [15:0]       stall_cnt
`endif
);

  localparam int unsigned IdxW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [0:0] {StIdle, StBurst} state_e;

  state_e          state_q, state_d;
  logic [IdxW-1:0] owner_q, owner_d;
  logic [IdxW-1:0] last_q, last_d;
  logic [3:0]      cnt_q, cnt_d;

  logic [NREQ-1:0] gnt;
  logic [NREQ-1:0] ack;
  logic            wr_en;
  logic [IdxW-1:0] pick;
  logic            found;
  int unsigned     idx;

  // Grant is decoded from registered state only, so reset clears it without a clock.
  always_comb begin
    gnt = '0;
    if (state_q == StBurst) gnt[owner_q] = 1'b1;
  end

  assign ack   = gnt & bus.req & {NREQ{~bus.buf_full}};
  assign wr_en = |ack;

  assign bus.gnt    = gnt;
  assign bus.ack    = ack;
  assign bus.wr_en  = wr_en;
  assign bus.buf_in = wr_en ? bus.req_data[owner_q*DW +: DW] : '0;
  assign bus.busy   = (state_q == StBurst);

  // Round-robin search starting just after the previous owner.
  always_comb begin
    pick  = last_q;
    found = 1'b0;
    idx   = 0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      idx = (int'(last_q) + i) % NREQ;
      if (!found && bus.req[idx]) begin
        found = 1'b1;
        pick  = IdxW'(idx);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (found) begin
          state_d = StBurst;
          owner_d = pick;
          cnt_d   = '0;
        end
      end
      StBurst: begin
        if (!bus.req[owner_q]) begin
          state_d = StIdle;
          last_d  = owner_q;
        end else if (wr_en) begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_q + 4'd1 == 4'(MAX_BURST)) begin
            state_d = StIdle;
            last_d  = owner_q;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      owner_q <= '0;
      last_q  <= IdxW'(NREQ - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef FIFO_WR_ARB_STATS_EN
  logic stall;
  assign stall = (state_q == StBurst) & bus.req[owner_q] & bus.buf_full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      words_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (wr_en && words_cnt != 16'hFFFF) words_cnt <= words_cnt + 16'd1;
      if (stall && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: per-cycle vector table plus a write-data
// scoreboard, followed by a hand-written asynchronous reset sequence.
module tb_fifo_wr_arbiter;
  localparam int unsigned NREQ = 4;
  localparam int unsigned DW   = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  fifo_wr_arbiter_if #(.NREQ(NREQ), .DW(DW)) bus ();

`ifdef FIFO_WR_ARB_STATS_EN
  logic [15:0] words_cnt;
  logic [15:0] stall_cnt;
`endif

  fifo_wr_arbiter #(
    .NREQ      (NREQ),
    .DW        (DW),
    .MAX_BURST (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus)
`ifdef FIFO_WR_ARB_STATS_EN
    ,
    .words_cnt (words_cnt),
    .stall_cnt (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] req;
    logic       full;
    logic [3:0] gnt;
    logic [3:0] ack;
    logic       wr;
    logic [7:0] data;
    logic       busy;
  } vec_t;

  vec_t       vecs[$];
  logic [7:0] exp_q[$];
  logic [7:0] dat[4] = '{8'hC3, 8'h3C, 8'h5A, 8'hA5};
  int         checks = 0;
  int         errors = 0;
  int         exp_words = 0;
  int         exp_stalls = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic [3:0] r, input logic f, input logic [3:0] g,
                     input logic [3:0] a, input logic w, input logic [7:0] d,
                     input logic b);
    vec_t v;
    v.req = r; v.full = f; v.gnt = g; v.ack = a; v.wr = w; v.data = d; v.busy = b;
    vecs.push_back(v);
  endtask

  task automatic burst_word(input logic [3:0] r, input int o);
    add(r, 1'b0, 4'(1 << o), 4'(1 << o), 1'b1, dat[o], 1'b1);
  endtask

  task automatic sb_sample(input string tag);
    logic [7:0] e;
    if (bus.wr_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL %s_sb: got unexpected write %0h expected none", tag, bus.buf_in);
      end else begin
        e = exp_q.pop_front();
        chk({tag, "_sb"}, bus.buf_in, e);
      end
    end
  endtask

  initial begin
    bus.req      = 4'hF;
    bus.buf_full = 1'b0;
    bus.req_data = {dat[3], dat[2], dat[1], dat[0]};

    // Full rotation: 0,1,2,3,0, four words each, one idle bubble before every grant.
    for (int g = 0; g < 5; g++) begin
      add(4'hF, 1'b0, 4'h0, 4'h0, 1'b0, 8'h00, 1'b0);
      for (int w = 0; w < 4; w++) burst_word(4'hF, g % 4);
    end
    add(4'h0, 1'b0, 4'h0, 4'h0, 1'b0, 8'h00, 1'b0);
    // Short burst ended by req drop, then round-robin wraps to requester 0.
    add(4'h4, 1'b0, 4'h0, 4'h0, 1'b0, 8'h00, 1'b0);
    burst_word(4'h4, 2);
    burst_word(4'h4, 2);
    add(4'h0, 1'b0, 4'h4, 4'h0, 1'b0, 8'h00, 1'b1);
    add(4'h5, 1'b0, 4'h0, 4'h0, 1'b0, 8'h00, 1'b0);
    burst_word(4'h5, 0);
    add(4'h0, 1'b0, 4'h1, 4'h0, 1'b0, 8'h00, 1'b1);
    // Owner 1 stalled by buf_full for five cycles at burst_cnt=2.
    add(4'h2, 1'b0, 4'h0, 4'h0, 1'b0, 8'h00, 1'b0);
    burst_word(4'h2, 1);
    burst_word(4'h2, 1);
    for (int s = 0; s < 5; s++) add(4'h2, 1'b1, 4'h2, 4'h0, 1'b0, 8'h00, 1'b1);
    burst_word(4'h2, 1);
    burst_word(4'h2, 1);
    add(4'h0, 1'b0, 4'h0, 4'h0, 1'b0, 8'h00, 1'b0);

    foreach (vecs[i]) begin
      if (vecs[i].wr) exp_words++;
      if (vecs[i].full && vecs[i].busy) exp_stalls++;
    end

    // Reset state, with requests already asserted.
    repeat (2) @(negedge clk);
    #1;
    chk("rst_gnt", bus.gnt, 4'h0);
    chk("rst_ack", bus.ack, 4'h0);
    chk("rst_wr_en", bus.wr_en, 1'b0);
    chk("rst_buf_in", bus.buf_in, 8'h00);
    chk("rst_busy", bus.busy, 1'b0);
    @(negedge clk);
    rst_n   = 1'b1;
    bus.req = 4'h0;

    foreach (vecs[i]) begin
      @(negedge clk);
      bus.req      = vecs[i].req;
      bus.buf_full = vecs[i].full;
      if (vecs[i].wr) exp_q.push_back(vecs[i].data);
      #1;
      chk($sformatf("v%0d_gnt", i), bus.gnt, vecs[i].gnt);
      chk($sformatf("v%0d_ack", i), bus.ack, vecs[i].ack);
      chk($sformatf("v%0d_wr_en", i), bus.wr_en, vecs[i].wr);
      chk($sformatf("v%0d_buf_in", i), bus.buf_in, vecs[i].wr ? vecs[i].data : 8'h00);
      chk($sformatf("v%0d_busy", i), bus.busy, vecs[i].busy);
      sb_sample($sformatf("v%0d", i));
    end
    chk("sb_empty", exp_q.size(), 0);

`ifdef FIFO_WR_ARB_STATS_EN
    chk("words_cnt", words_cnt, exp_words);
    chk("stall_cnt", stall_cnt, exp_stalls);
`endif

    // Reset pulsed mid-burst of owner 3; outputs must drop before any clock edge.
    @(negedge clk);
    bus.req = 4'h8;
    @(negedge clk);
    #1;
    chk("pre_rst_gnt", bus.gnt, 4'h8);
    chk("pre_rst_buf_in", bus.buf_in, 8'hA5);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_gnt", bus.gnt, 4'h0);
    chk("async_wr_en", bus.wr_en, 1'b0);
    chk("async_busy", bus.busy, 1'b0);
    chk("async_buf_in", bus.buf_in, 8'h00);
    @(negedge clk);
    rst_n   = 1'b1;
    bus.req = 4'h6;
    #1;
    chk("post_rst_idle", bus.gnt, 4'h0);
    @(negedge clk);
    #1;
    chk("post_rst_gnt", bus.gnt, 4'h2);
    chk("post_rst_ack", bus.ack, 4'h2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
